// File: rtl/edge_out_stage.sv
// Output stage after the Sobel convolution: optional binarisation, row/frame tagging,
// a small FIFO with a registered head, and frame completion / overflow reporting.
module edge_out_stage #(
  parameter int OUT_W = 218,
  parameter int OUT_H = 218,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               pxl_in,
  input  logic                     valid_in,
  input  logic                     bin_en,
  input  logic [7:0]               thresh,
  output logic [7:0]               pxl_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_eol,
  output logic                     out_last,
  output logic                     frame_done,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] COL_MAX = CW'(OUT_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(OUT_H - 1);

  // IDLE: no frame | RUN: accepting frame | DRAIN: last pixel queued or dropped | DONE: frame_done pulse
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    data;
  logic [9:0]    wr_entry;
  logic          at_eol, at_last, rd, wr, last_dropped;

  always_comb begin
    data = pxl_in;
    if (bin_en) data = (pxl_in >= thresh) ? 8'hFF : 8'h00;
  end

  assign at_eol   = (col == COL_MAX);
  assign at_last  = at_eol && (row == ROW_MAX);
  assign wr_entry = {at_last, at_eol, data};
  assign rd       = out_valid && out_ready;
  assign wr       = valid_in && ((fill != FULL) || rd);
  assign rd_next  = rd_ptr + PTR_ONE;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      col          <= '0;
      row          <= '0;
      pxl_out      <= '0;
      out_valid    <= 1'b0;
      out_eol      <= 1'b0;
      out_last     <= 1'b0;
      overflow     <= 1'b0;
      frame_done   <= 1'b0;
      last_dropped <= 1'b0;
      state        <= IDLE;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd) rd_ptr <= rd_next;
      if (wr && !rd) fill <= fill + ONE;
      else if (rd && !wr) fill <= fill - ONE;
      if (valid_in && !wr) overflow <= 1'b1;

      // Geometry advances even for dropped pixels so tags stay frame-aligned.
      if (valid_in) begin
        if (at_eol) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      // Head register: a fresh write into an empty FIFO becomes visible one edge later,
      // but a read at fill=1 forwards the simultaneous write to avoid a bubble.
      if (rd) begin
        if (fill > ONE) begin
          {out_last, out_eol, pxl_out} <= mem[rd_next];
          out_valid <= 1'b1;
        end else if (wr) begin
          {out_last, out_eol, pxl_out} <= wr_entry;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (!out_valid && fill != '0) begin
        {out_last, out_eol, pxl_out} <= mem[rd_ptr];
        out_valid <= 1'b1;
      end

      if (valid_in && at_last) last_dropped <= !wr;

      frame_done <= 1'b0;
      case (state)
        IDLE:  if (valid_in) state <= at_last ? DRAIN : RUN;
        RUN:   if (valid_in && at_last) state <= DRAIN;
        DRAIN: begin
          if (last_dropped ? (fill == '0) : (rd && out_last)) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE:  state <= valid_in ? (at_last ? DRAIN : RUN) : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
